icache: RTL and testbench

Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory controller. It answers fetch-stage requests (`imemREN`/`imemaddr`) with `ihit`/`imemload` in the same cycle on a hit. On a miss it runs a one-word fill through the controller's instruction port (`iREN`/`iaddr`/`iwait`/`iload`), stores the word, then hits on the following cycle. The fetch stage holds `imemaddr` until `ihit`; the cache does not depend on that.

---
 rtl/icache_if.sv | 22 ++
 rtl/icache.sv | 118 +++++++++++
 tb/tb_icache.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-stage and memory-controller instruction-port signals of the icache.
// master: datapath/controller side; slave: the cache.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a one-word fill per miss.
// Optional ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 r_state;
  logic                   r_iren;
  logic [31:0]            r_iaddr;
  logic [29:0]            r_miss_addr;
  logic [SETS-1:0]        r_valid;
  logic [TAG_W-1:0]       r_tag  [SETS];
  logic [31:0]            r_data [SETS];

  logic [IDX_W-1:0]       w_index;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_match;
  logic                   w_miss;
  logic                   w_fill_done;
  logic [IDX_W-1:0]       w_fill_idx;
  logic [TAG_W-1:0]       w_fill_tag;
  logic                   w_unused_ok;

  assign w_index     = bus.imemaddr[IDX_W+1:2];
  assign w_tag       = bus.imemaddr[31:IDX_W+2];
  assign w_match     = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss      = (r_state == IDLE) && bus.imemREN && !w_match;
  assign w_fill_done = (r_state == FILL) && !bus.iwait;
  assign w_fill_idx  = r_miss_addr[IDX_W-1:0];
  assign w_fill_tag  = r_miss_addr[29:IDX_W];
  assign w_unused_ok = &{1'b0, bus.imemaddr[1:0]};

  assign bus.ihit     = (r_state == IDLE) && bus.imemREN && w_match;
  assign bus.imemload = w_match ? r_data[w_index] : 32'h0;
  assign bus.iREN     = r_iren;
  assign bus.iaddr    = r_iaddr;

  // Control FSM; iREN/iaddr come straight from flops so fill requests never see imemaddr glitches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_iren      <= 1'b0;
      r_iaddr     <= 32'h0;
      r_miss_addr <= 30'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state     <= FILL;
            r_miss_addr <= {w_tag, w_index};
            r_iren      <= 1'b1;
            r_iaddr     <= {w_tag, w_index, 2'b00};
          end
        end
        FILL: begin
          if (!bus.iwait) begin
            r_state <= IDLE;
            r_iren  <= 1'b0;
            r_iaddr <= 32'h0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_iren  <= 1'b0;
          r_iaddr <= 32'h0;
        end
      endcase
    end
  end

  // Frame array; a fill overwrites its frame regardless of prior contents.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_tag[s]  <= '0;
        r_data[s] <= 32'h0;
      end
    end else if (w_fill_done) begin
      r_valid[w_fill_idx] <= 1'b1;
      r_tag[w_fill_idx]   <= w_fill_tag;
      r_data[w_fill_idx]  <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else begin
      if (bus.ihit) r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss)   r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized bench for icache against a frame-array reference model.
module tb_icache;
  localparam int unsigned SETS = 16;

  logic CLK;
  logic RST;
  icache_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.SETS(SETS)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int n_hits = 0;
  int n_miss = 0;

  bit          mv [SETS];
  logic [31:0] mt [SETS];
  logic [31:0] md [SETS];

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a / 4) % SETS;
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] a);
    return a / (4 * SETS);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2001_0005;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
    n_hits = 0;
    n_miss = 0;
  endtask

  task automatic fill_cycles(input logic [31:0] a, input int n_wait);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    for (int c = 0; c < n_wait; c++) begin
      check("iREN_wait", 32'(bus.iREN), 32'd1);
      check("iaddr_wait", bus.iaddr, wa);
      check("ihit_fill", 32'(bus.ihit), 32'd0);
      tick();
    end
    bus.iwait = 1'b0;
    bus.iload = mem_word(wa);
    #1;
    check("iREN_last", 32'(bus.iREN), 32'd1);
    check("iaddr_last", bus.iaddr, wa);
    tick();
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    mv[m_idx(wa)] = 1'b1;
    mt[m_idx(wa)] = m_tag(wa);
    md[m_idx(wa)] = mem_word(wa);
  endtask

  // One fetch of address a: hit in place, or miss + fill with n_wait busy cycles then the hit.
  task automatic access(input logic [31:0] a, input int n_wait);
    int unsigned i;
    logic        hit;
    i   = m_idx(a);
    hit = mv[i] && (mt[i] == m_tag(a));
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    bus.iwait    = 1'b1;
    #1;
    check("ihit_c0", 32'(bus.ihit), 32'(hit));
    check("iREN_c0", 32'(bus.iREN), 32'd0);
    check("iaddr_c0", bus.iaddr, 32'd0);
    if (hit) begin
      check("load_hit", bus.imemload, md[i]);
      n_hits++;
      tick();
      return;
    end
    n_miss++;
    tick();
    fill_cycles(a, n_wait);
    #1;
    check("ihit_after_fill", 32'(bus.ihit), 32'd1);
    check("iREN_after_fill", 32'(bus.iREN), 32'd0);
    check("load_after_fill", bus.imemload, mem_word(a & 32'hFFFF_FFFC));
    n_hits++;
    tick();
  endtask

  task automatic idle_cycle(input logic [31:0] a);
    bus.imemREN  = 1'b0;
    bus.imemaddr = a;
    #1;
    check("ihit_idle", 32'(bus.ihit), 32'd0);
    check("iREN_idle", 32'(bus.iREN), 32'd0);
    tick();
  endtask

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hits"}, hit_count, 32'(n_hits));
    check({tag, "_misses"}, miss_count, 32'(n_miss));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    RST          = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;
    model_clear();

    // Reset values
    #1 RST = 1'b1;
    #1;
    check("rst_ihit", 32'(bus.ihit), 32'd0);
    check("rst_imemload", bus.imemload, 32'd0);
    check("rst_iREN", 32'(bus.iREN), 32'd0);
    check("rst_iaddr", bus.iaddr, 32'd0);
    tick();
    tick();
    RST = 1'b0;
    check_stats("rst");

    // First fill of 0x0 with immediate memory response, then a same-cycle hit
    access(32'h0000_0000, 0);
    check("first_word", md[0], 32'h2001_0005);
    access(32'h0000_0000, 0);

    // Conflict: 0x04 and 0x44 share an index
    access(32'h0000_0004, 0);
    access(32'h0000_0044, 1);
    access(32'h0000_0004, 0);
    access(32'h0000_0044, 0);

    // Long wait: iREN/iaddr stable for 6 cycles, ihit 7 cycles after the miss
    access(32'h0000_0108, 5);
    access(32'h0000_010B, 0);
    check_stats("directed");

    // Reset mid-fill drops iREN asynchronously and clears all frames
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0200;
    bus.iwait    = 1'b1;
    tick();
    check("fill_started", 32'(bus.iREN), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_mid_iREN", 32'(bus.iREN), 32'd0);
    check("rst_mid_iaddr", bus.iaddr, 32'd0);
    check("rst_mid_ihit", 32'(bus.ihit), 32'd0);
    model_clear();
    tick();
    RST = 1'b0;
    check_stats("rst_mid");
    access(32'h0000_0000, 0);

    // Address switched from 0x10 to 0x80 mid-fill: 0x10 still fills, then 0x80 misses
    model_clear();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0010;
    #1;
    check("sw_miss", 32'(bus.ihit), 32'd0);
    n_miss++;
    tick();
    bus.imemaddr = 32'h0000_0080;
    fill_cycles(32'h0000_0010, 2);
    access(32'h0000_0080, 0);
    access(32'h0000_0010, 0);
    idle_cycle(32'h0000_0010);
    check_stats("switch");

    // Randomized traffic over a small address window to mix hits and conflicts
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle_cycle(a);
      else access(a, int'($urandom_range(0, 3)));
    end
    check_stats("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
